// File: rtl/load_store_unit_if.sv
// Execute-stage request/response handshake plus the data-memory port of the
// load/store unit, bundled so both sides see one consistent signal set.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_fault;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // slave = the load/store unit; master = requester plus memory
    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// One-at-a-time load/store sequencer for a 16-bit word memory with a
// registered 1-cycle read; byte stores become read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, READ, RDATA, WRITE, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic        is_byte;
        logic        sgn;
        logic [15:0] addr;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        fault_q;

    logic        accept;
    logic        fault_in;
    logic [7:0]  sel_byte;
    logic [15:0] load_res;
    logic [15:0] merged;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign fault_in = (32'(bus.req_addr) >= MEM_BYTES) ||
                      (!bus.req_byte && bus.req_addr[0]);

    // wdata_q still holds the captured store data when the read word arrives
    assign sel_byte = req_q.addr[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
    assign load_res = !req_q.is_byte ? bus.mem_rdata :
                      {(req_q.sgn ? {8{sel_byte[7]}} : 8'h00), sel_byte};
    assign merged   = req_q.addr[0] ? {wdata_q[7:0], bus.mem_rdata[7:0]}
                                    : {bus.mem_rdata[15:8], wdata_q[7:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault_in)
                        state_d = RESP;
                    else if (bus.req_write && !bus.req_byte)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = RDATA;
            RDATA:   state_d = req_q.write ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q.write   <= bus.req_write;
                req_q.is_byte <= bus.req_byte;
                req_q.sgn     <= bus.req_signed;
                req_q.addr    <= bus.req_addr;
                wdata_q       <= bus.req_wdata;
                rdata_q       <= '0;
                fault_q       <= fault_in;
            end
            if (state_q == RDATA) begin
                if (req_q.write)
                    wdata_q <= merged;
                else
                    rdata_q <= load_res;
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;

    // Gating with rst_n keeps a reset edge during WRITE from committing a store
    assign bus.mem_write  = (state_q == WRITE) && rst_n;
    assign bus.mem_addr   = req_q.addr;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory
// and a word-array reference model of the load/store rules.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(8192)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: registered read, word at previous cycle's address
    logic [15:0] mem [4096] = '{default: 16'h0};
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[12:1]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[12:1]];
    end

    typedef struct {
        logic [15:0] rdata;
        logic        fault;
        int          lat;
        int          nwr;
        logic [15:0] waddr;
        logic [15:0] wdata;
    } exp_t;

    exp_t      q[$];
    bit [15:0] sh [4096];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: shadow word array, result computed from the access rules
    function automatic exp_t model(bit w, bit b, bit s, bit [15:0] a, bit [15:0] d);
        exp_t        e;
        bit [15:0]   old;
        bit [7:0]    bt;
        int unsigned wi;
        wi = int'(a) / 2;
        e.rdata = 16'h0; e.fault = 1'b0; e.lat = 0; e.nwr = 0;
        e.waddr = a; e.wdata = 16'h0;
        if (int'(a) >= 8192 || (!b && (a % 2 == 1))) begin
            e.fault = 1'b1;
            e.lat   = 1;
        end else begin
            old = sh[wi];
            bt  = (a % 2 == 1) ? old[15:8] : old[7:0];
            if (w) begin
                if (!b)               sh[wi] = d;
                else if (a % 2 == 1)  sh[wi] = {d[7:0], old[7:0]};
                else                  sh[wi] = {old[15:8], d[7:0]};
                e.wdata = sh[wi];
                e.nwr   = 1;
                e.lat   = b ? 4 : 2;
            end else begin
                e.rdata = !b ? old : (s ? 16'($signed(bt)) : 16'(bt));
                e.lat   = 3;
            end
        end
        return e;
    endfunction

    // Monitor: pops one expectation per accept, checks writes and the response
    int   acc_cyc = 0;
    bit   busy = 0;
    int   wr_cnt = 0;
    bit   have_cur = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("mem_write_in_reset", bus.mem_write, 0);
            busy     = 0;
            have_cur = 0;
            wr_cnt   = 0;
        end else begin
            if (busy) chk("ready_busy", bus.req_ready, 0);
            if (bus.mem_write) begin
                wr_cnt++;
                if (!have_cur) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h", bus.mem_addr, bus.mem_wdata);
                end else begin
                    chk("write_addr", bus.mem_addr, cur.waddr);
                    chk("write_data", bus.mem_wdata, cur.wdata);
                end
            end
            if (bus.resp_valid) begin
                if (!have_cur) begin
                    errors++;
                    $display("FAIL unexpected_resp: rdata %h fault %b", bus.resp_rdata, bus.resp_fault);
                end else begin
                    chk("resp_rdata", bus.resp_rdata, cur.rdata);
                    chk("resp_fault", bus.resp_fault, cur.fault);
                    chk("resp_latency", cyc - acc_cyc, cur.lat);
                    chk("write_count", wr_cnt, cur.nwr);
                end
                have_cur = 0;
                busy     = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                busy    = 1;
                acc_cyc = cyc;
                wr_cnt  = 0;
                if (q.size() != 0) begin
                    cur      = q.pop_front();
                    have_cur = 1;
                end else begin
                    have_cur = 0;
                end
            end
        end
    end

    task automatic drive_req(bit w, bit b, bit s, bit [15:0] a, bit [15:0] d);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    // While busy, optionally keep req_valid high with junk that must be ignored
    task automatic issue(bit w, bit b, bit s, bit [15:0] a, bit [15:0] d, bit garbage);
        int  guard = 0;
        bit  go = 0;
        while (!go) begin
            @(posedge clk); #1;
            if (bus.req_ready) go = 1;
            else if (guard > 200) begin
                errors++;
                $display("FAIL ready_timeout: req_ready %b expected 1", bus.req_ready);
                go = 1;
            end else if (garbage)
                drive_req(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            else
                bus.req_valid = 1'b0;
            guard++;
        end
        drive_req(w, b, s, a, d);
        q.push_back(model(w, b, s, a, d));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((q.size() != 0 || busy) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (q.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", q.size());
        end
    endtask

    initial begin
        drive_req(0, 0, 0, 16'h0, 16'h0);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_fault", bus.resp_fault, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;

        // Word round trip
        issue(1, 0, 0, 16'h0010, 16'hBEEF, 0);
        issue(0, 0, 0, 16'h0010, 16'h0000, 0);
        // Byte read-modify-write
        issue(1, 0, 0, 16'h0020, 16'h1234, 0);
        issue(1, 1, 0, 16'h0021, 16'h00AB, 0);
        issue(0, 0, 0, 16'h0020, 16'h0000, 0);
        issue(1, 1, 0, 16'h0020, 16'h77CD, 0);
        issue(0, 0, 0, 16'h0020, 16'h0000, 0);
        // Byte loads with sign/zero extension
        issue(1, 0, 0, 16'h0030, 16'h80F0, 0);
        issue(0, 1, 1, 16'h0031, 16'h0000, 0);
        issue(0, 1, 0, 16'h0031, 16'h0000, 0);
        issue(0, 1, 1, 16'h0030, 16'h0000, 0);
        // Faults: misaligned word, out of range, last valid byte
        issue(0, 0, 0, 16'h0005, 16'h0000, 0);
        issue(1, 0, 0, 16'h2000, 16'h1111, 0);
        issue(1, 1, 0, 16'h1FFF, 16'h00EE, 0);
        issue(0, 1, 0, 16'h1FFF, 16'h0000, 0);
        issue(0, 1, 0, 16'h2000, 16'h0000, 0);
        // Handshake: junk held on req_* while busy
        issue(1, 0, 0, 16'h0050, 16'hA5A5, 1);
        issue(0, 0, 0, 16'h0050, 16'h0000, 1);
        issue(0, 1, 1, 16'h0051, 16'h0000, 1);

        for (int i = 0; i < 300; i++) begin
            bit [15:0] a;
            if ($urandom_range(0, 9) == 0)
                a = 16'h2000 + 16'($urandom_range(0, 16'hDFFF));
            else
                a = 16'($urandom_range(0, 127));
            issue(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom));
        end
        wait_idle();

        // Reset during WRITE of a byte store aborts without writing or responding
        issue(1, 0, 0, 16'h0040, 16'h5555, 0);
        wait_idle();
        @(posedge clk); #1;
        drive_req(1, 1, 0, 16'h0040, 16'h00AA);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_reset", bus.req_ready, 1);
        chk("abort_mem_word", mem[12'h020], 16'h5555);
        issue(0, 0, 0, 16'h0040, 16'h0000, 0);
        issue(0, 1, 0, 16'h0040, 16'h0000, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
